wb_write_queue: RTL and testbench

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

---
 rtl/wb_write_queue.sv | 72 +++++++
 tb/tb_wb_write_queue.sv | 109 ++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// wb_write_queue: circular writeback FIFO draining one entry per cycle into a registered
// register-file write port, with youngest-first forwarding lookups for decode.
module wb_write_queue #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid,
  output logic                     wb_ready,
  input  logic [ADDRESS_WIDTH-1:0] wb_dest,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  output logic                     rg_wrt_en,
  output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rg_wrt_data,
  input  logic [ADDRESS_WIDTH-1:0] lk_addr1,
  input  logic [ADDRESS_WIDTH-1:0] lk_addr2,
  output logic                     lk_hit1,
  output logic                     lk_hit2,
  output logic [DATA_WIDTH-1:0]    lk_data1,
  output logic [DATA_WIDTH-1:0]    lk_data2,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDRESS_WIDTH-1:0] dest_q [DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [DEPTH];
  logic [PW-1:0]            head, tail;
  logic                     push, pop;
  assign wb_ready = count < CW'(DEPTH);
  assign push     = wb_valid && wb_ready && wb_dest != '0;
  assign pop      = count != '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      rg_wrt_en   <= 1'b0;
      rg_wrt_dest <= '0;
      rg_wrt_data <= '0;
    end else begin
      head      <= head + PW'(pop);
      tail      <= tail + PW'(push);
      count     <= count + CW'(push) - CW'(pop);
      rg_wrt_en <= pop;
      if (pop) begin
        rg_wrt_dest <= dest_q[head];
        rg_wrt_data <= data_q[head];
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      dest_q[tail] <= wb_dest;
      data_q[tail] <= wb_data;
    end
  // Scan oldest to youngest so the youngest match wins; the output register is older than every entry.
  function automatic logic [DATA_WIDTH:0] look(input logic [ADDRESS_WIDTH-1:0] a);
    logic [DATA_WIDTH:0] r;
    logic [PW-1:0]       idx;
    r = (rg_wrt_en && rg_wrt_dest == a) ? {1'b1, rg_wrt_data} : '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count && dest_q[idx] == a) r = {1'b1, data_q[idx]};
    end
    return (a == '0) ? '0 : r;
  endfunction
  always_comb begin
    {lk_hit1, lk_data1} = look(lk_addr1);
    {lk_hit2, lk_data2} = look(lk_addr2);
  end
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: randomized and directed stimulus checked against a queue-based reference model.
module tb_wb_write_queue;
  localparam int DW = 32, AW = 5, DEPTH = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic wb_valid = 1'b0, wb_ready;
  logic [AW-1:0] wb_dest = '0, rg_wrt_dest, lk_addr1 = '0, lk_addr2 = '0;
  logic [DW-1:0] wb_data = '0, rg_wrt_data, lk_data1, lk_data2;
  logic rg_wrt_en, lk_hit1, lk_hit2;
  logic [$clog2(DEPTH):0] count;
  int n_cmp = 0, n_bad = 0;
  typedef struct { logic [AW-1:0] d; logic [DW-1:0] v; } ent_t;
  ent_t q[$];
  logic m_en = 1'b0;
  logic [AW-1:0] m_dest = '0;
  logic [DW-1:0] m_data = '0;
  wb_write_queue #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest),
    .wb_data(wb_data), .rg_wrt_en(rg_wrt_en), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
    .lk_addr1(lk_addr1), .lk_addr2(lk_addr2), .lk_hit1(lk_hit1), .lk_hit2(lk_hit2),
    .lk_data1(lk_data1), .lk_data2(lk_data2), .count(count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Youngest pending write wins; the register-file output stage counts as oldest.
  function automatic logic [DW:0] model_look(input logic [AW-1:0] a);
    if (a == 0) return '0;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].d == a) return {1'b1, q[i].v};
    if (m_en && m_dest == a) return {1'b1, m_data};
    return '0;
  endfunction
  task automatic check_all();
    logic [DW:0] l1, l2;
    l1 = model_look(lk_addr1);
    l2 = model_look(lk_addr2);
    check("count", 64'(count), 64'(q.size()));
    check("wb_ready", 64'(wb_ready), 64'(q.size() < DEPTH));
    check("rg_wrt_en", 64'(rg_wrt_en), 64'(m_en));
    check("rg_wrt_dest", 64'(rg_wrt_dest), 64'(m_dest));
    check("rg_wrt_data", 64'(rg_wrt_data), 64'(m_data));
    check("lk1", {31'b0, lk_hit1, lk_data1}, 64'(l1));
    check("lk2", {31'b0, lk_hit2, lk_data2}, 64'(l2));
  endtask
  task automatic step(input logic v, input logic [AW-1:0] d, input logic [DW-1:0] x,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    logic rdy;
    wb_valid = v; wb_dest = d; wb_data = x; lk_addr1 = a1; lk_addr2 = a2;
    @(negedge clk);
    check_all();
    @(posedge clk);
    rdy = q.size() < DEPTH;
    m_en = q.size() > 0;
    if (m_en) begin
      m_dest = q[0].d;
      m_data = q[0].v;
      void'(q.pop_front());
    end
    if (v && rdy && d != 0) q.push_back('{d, x});
    #1;
  endtask
  initial begin
    #2;
    check("rst_count", 64'(count), 0);
    check("rst_ready", 64'(wb_ready), 1);
    check("rst_en", 64'(rg_wrt_en), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    step(1, 5, 32'hDEADBEEF, 5, 0);
    step(0, 0, 0, 5, 0);
    step(0, 0, 0, 5, 0);
    step(0, 0, 0, 5, 0);
    step(1, 0, 32'h1234, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 3, 32'h11, 3, 0);
    step(1, 3, 32'h22, 3, 3);
    step(0, 0, 0, 3, 0);
    step(0, 0, 0, 3, 0);
    step(0, 0, 0, 3, 0);
    for (int i = 0; i < 10; i++) step(1, AW'(i % 7 + 1), 32'hA000 + i, AW'(i % 7 + 1), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 2);
    step(1, 7, 32'hAA, 7, 0);
    step(0, 0, 0, 7, 0);
    #2;
    rst = 1'b0;
    #1;
    check("arst_count", 64'(count), 0);
    check("arst_en", 64'(rg_wrt_en), 0);
    check("arst_hit", 64'(lk_hit1), 0);
    check("arst_ready", 64'(wb_ready), 1);
    check("arst_data", 64'(rg_wrt_data), 0);
    q.delete(); m_en = 0; m_dest = '0; m_data = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 7, 0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), $urandom,
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
